// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: signed 32x32 -> 64-bit product.
// One recoding step per clock, fixed 32-step latency, results held until the next completion.
module booth_multiplier (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [32:0] a_q;
  logic [32:0] m_q;
  logic [31:0] q_q;
  logic        qm1_q;
  logic [5:0]  cnt_q;

  logic [32:0] sum_d;
  logic [32:0] a_d;
  logic [31:0] q_d;
  logic        qm1_d;

  // Booth add/subtract followed by arithmetic shift of {A,Q,Q-1}.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b10:   sum_d = a_q - m_q;
      2'b01:   sum_d = a_q + m_q;
      default: sum_d = a_q;
    endcase
    {a_d, q_d, qm1_d} = {sum_d[32], sum_d, q_q};
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            m_q     <= {multiplicand[31], multiplicand};
            q_q     <= multiplier;
            a_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StRun: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= StDone;
            hi      <= a_d[31:0];
            lo      <= q_d;
            done    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
